alu_ctrl_muldiv: RTL and testbench
==================================

ALU_CTRL_MULDIV -- requirements
Module: alu_ctrl_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 funct  input  6  R-type function field.
REQ-007 alu_op  input  2  main-decoder class: 00 ld/st, 01 branch, 10 R-type, 11 LUI.
REQ-008 op_valid  input  1  operands and funct valid this cycle.
REQ-009 op_a, op_b  input  WIDTH  dividend/multiplicand, divisor/multiplier.
REQ-010 alu_sel  output  4  combinational ALU select.
REQ-011 op_ready  output  1  unit can accept a mult/div op.
REQ-012 res_valid  output  1  res_hi/res_lo hold a completed result.
REQ-013 res_ready  input  1  consumer takes the result.
REQ-014 res_hi, res_lo  output  WIDTH  product high/low, or remainder/quotient.
REQ-015 div_by_zero  output  1  current result came from a zero divisor.
REQ-016 stall  output  1  pipeline hold request.

Function
REQ-017 alu_sel SHALL be combinational: default 8; alu_op 11 -> 5; alu_op 10 with funct 0x18->3, 0x1A->4, 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7; all else 8.
REQ-018 is_md SHALL be alu_op==10 and funct in {0x18,0x1A} (plus 0x19,0x1B per REQ-032).
REQ-019 FSM states IDLE, BUSY, DONE; op_ready SHALL equal (state==IDLE).
REQ-020 Accept SHALL occur on an edge with op_valid & op_ready & is_md; op_valid with !is_md SHALL be ignored.
REQ-021 Accept: capture operand magnitudes, result-sign flags, op kind; counter=0; IDLE->BUSY.
REQ-022 BUSY: one shift-add (mult) or restoring shift-subtract (div) iteration per cycle; after WIDTH iterations -> DONE, applying sign correction on the final edge.
REQ-023 res_valid SHALL be high exactly while in DONE; first high WIDTH cycles after the accept edge.
REQ-024 DIV accepted with op_b==0 SHALL skip BUSY: IDLE->DONE in one edge, res_lo=all ones, res_hi=op_a, div_by_zero=1.
REQ-025 Signed DIV: quotient truncates toward zero, remainder takes dividend's sign; -2**(WIDTH-1)/-1 SHALL yield res_lo=op_a, res_hi=0.
REQ-026 MULT: {res_hi,res_lo} SHALL be the full 2*WIDTH-bit signed product.
REQ-027 DONE with res_ready SHALL go to IDLE; a new op SHALL NOT be accepted on that same edge.
REQ-028 res_hi/res_lo/div_by_zero SHALL hold their value from entering DONE until the next accept.
REQ-029 stall SHALL equal (state!=IDLE) | (op_valid & is_md & !op_ready).

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, res_hi=res_lo=0, res_valid=0, div_by_zero=0, stall=0, op_ready=1, regardless of clock.
REQ-031 Reset during BUSY or DONE SHALL abort the op with no result; first accept possible on the first edge after rst_n rises.

Configuration
REQ-032 Macro ALU_CTRL_UNSIGNED_EN defined: funct 0x19 (MULTU) -> alu_sel 9, 0x1B (DIVU) -> alu_sel 10, both is_md, operands unsigned, no sign correction, same latency and zero-divisor rule.
REQ-033 Macro undefined: 0x19/0x1B SHALL decode to alu_sel 8 and SHALL NOT be accepted.

Verification
REQ-034 WIDTH=32, alu_op=10 sweep funct 0x18,0x1A,0x20,0x22,0x24,0x25,0x2A,0x00; alu_op 00/01/11 -> alu_sel 3,4,2,6,0,1,7,8; 8,8,5.
REQ-035 MULT op_a=-3, op_b=7 -> res_valid 32 cycles after accept, res_hi=0xFFFFFFFF, res_lo=0xFFFFFFEB; stall high throughout.
REQ-036 DIV op_a=-7, op_b=2 -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF, div_by_zero=0; DIV 5/0 -> res_valid after 1 edge, res_lo=0xFFFFFFFF, res_hi=5, div_by_zero=1.
REQ-037 res_ready held low 10 cycles in DONE with op_valid high -> result stable, op_ready=0, no accept; res_ready pulse -> IDLE, accept next edge.
REQ-038 rst_n low at BUSY cycle 12 -> all outputs reset values immediately; new MULT 6*7 after release -> res_lo=42, res_hi=0.
REQ-039 With ALU_CTRL_UNSIGNED_EN: MULTU 0xFFFFFFFF*2 -> res_hi=1, res_lo=0xFFFFFFFE; without: funct 0x19 -> alu_sel 8, op_ready stays 1.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// rtl/alu_ctrl_muldiv.sv - ALU select decoder plus iterative multiply/divide unit.
// Optional macro ALU_CTRL_UNSIGNED_EN adds MULTU/DIVU decoding and unsigned operation.
module alu_ctrl_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       funct,
    input  logic [1:0]       alu_op,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_sel,
    output logic             op_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero,
    output logic             stall
);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             is_md;
    logic             md_div;
    logic             md_signed;
    logic             accept;
    logic             div_zero;
    logic             last_iter;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic             dbz_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic             sub_ok;
    logic [WIDTH-1:0] sub_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

    always_comb begin
        alu_sel = 4'd8;
        if (alu_op == 2'b11) begin
            alu_sel = 4'd5;
        end else if (alu_op == 2'b10) begin
            case (funct)
                F_MULT:  alu_sel = 4'd3;
                F_DIV:   alu_sel = 4'd4;
                F_ADD:   alu_sel = 4'd2;
                F_SUB:   alu_sel = 4'd6;
                F_AND:   alu_sel = 4'd0;
                F_OR:    alu_sel = 4'd1;
                F_SLT:   alu_sel = 4'd7;
`ifdef ALU_CTRL_UNSIGNED_EN
                F_MULTU: alu_sel = 4'd9;
                F_DIVU:  alu_sel = 4'd10;
`endif
                default: alu_sel = 4'd8;
            endcase
        end
    end

    always_comb begin
        is_md     = 1'b0;
        md_div    = 1'b0;
        md_signed = 1'b1;
        if (alu_op == 2'b10) begin
            case (funct)
                F_MULT: is_md = 1'b1;
                F_DIV: begin
                    is_md  = 1'b1;
                    md_div = 1'b1;
                end
`ifdef ALU_CTRL_UNSIGNED_EN
                F_MULTU: begin
                    is_md     = 1'b1;
                    md_signed = 1'b0;
                end
                F_DIVU: begin
                    is_md     = 1'b1;
                    md_div    = 1'b1;
                    md_signed = 1'b0;
                end
`else
                F_MULTU, F_DIVU: is_md = 1'b0;
`endif
                default: is_md = 1'b0;
            endcase
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign res_valid = (state_q == S_DONE);
    assign stall     = (state_q != S_IDLE) | (op_valid & is_md & ~op_ready);
    assign accept    = op_valid & op_ready & is_md;
    assign div_zero  = md_div & (op_b == '0);
    assign last_iter = (state_q == S_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = div_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The iteration core works on magnitudes; signs are re-applied on the final edge.
    assign a_neg = md_signed & op_a[WIDTH-1];
    assign b_neg = md_signed & op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Multiply: hi_q accumulates, lo_q holds the multiplier shifting out to the right.
    // Divide: hi_q is the partial remainder, lo_q shifts dividend out and quotient in.
    assign add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign shl      = {hi_q, lo_q[WIDTH-1]};
    assign sub_ok   = (shl >= {1'b0, opnd_q});
    assign sub_diff = shl[WIDTH-1:0] - opnd_q;

    always_comb begin
        if (div_q) begin
            step_hi = sub_ok ? sub_diff : shl[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], sub_ok};
        end else begin
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        if (div_q) begin
            fin_lo = neg_lo_q ? -step_lo : step_lo;
            fin_hi = neg_hi_q ? -step_hi : step_hi;
        end else begin
            {fin_hi, fin_lo} = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            div_q    <= md_div;
            dbz_q    <= div_zero;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= md_div ? a_neg : (a_neg ^ b_neg);
            if (div_zero) begin
                hi_q <= op_a;
                lo_q <= '1;
            end else if (md_div) begin
                hi_q   <= '0;
                lo_q   <= a_mag;
                opnd_q <= b_mag;
            end else begin
                hi_q   <= '0;
                lo_q   <= b_mag;
                opnd_q <= a_mag;
            end
        end else if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                hi_q <= fin_hi;
                lo_q <= fin_lo;
            end else begin
                hi_q <= step_hi;
                lo_q <= step_lo;
            end
        end
    end

    assign res_hi      = hi_q;
    assign res_lo      = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb/tb_alu_ctrl_muldiv.sv - self-checking bench for alu_ctrl_muldiv.
module tb_alu_ctrl_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   funct = '0;
    logic [1:0]   alu_op = '0;
    logic         op_valid = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   alu_sel;
    logic         op_ready;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;
    logic         div_by_zero;
    logic         stall;

    int n_tests = 0;
    int n_fail = 0;

    alu_ctrl_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .funct(funct), .alu_op(alu_op),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .alu_sel(alu_sel),
        .op_ready(op_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(div_by_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] sel;
    } sel_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference results straight from integer arithmetic.
    function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        if (f == 6'h18) begin
            q  = sa * sb;
            hi = q[63:32];
            lo = q[31:0];
        end else if (f == 6'h19) begin
            uq = ua * ub;
            hi = uq[63:32];
            lo = uq[31:0];
        end else if (b == '0) begin
            dbz = 1'b1;
            lo  = '1;
            hi  = a;
        end else if (f == 6'h1A) begin
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            lo = uq[31:0];
            hi = ur[31:0];
        end
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_op   = 2'b10;
        funct    = f;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat, output bit stall_ok);
        lat = 0;
        stall_ok = 1'b1;
        while (!res_valid && lat < 200) begin
            if (!stall) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_res();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [5:0] f, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        logic         ed;
        int           lat;
        bit           st;
        model(f, a, b, eh, el, ed);
        issue(f, a, b);
        wait_res(lat, st);
        check({name, "_lat"}, lat, ed ? 0 : W);
        check({name, "_stall"}, st, 1);
        check({name, "_hi"}, res_hi, eh);
        check({name, "_lo"}, res_lo, el);
        check({name, "_dbz"}, div_by_zero, ed);
        release_res();
    endtask

    sel_vec_t vecs[13];

    initial begin
        logic [5:0] rf;
        logic [W-1:0] ra, rb;
        int lat;
        bit st, hold_ok;

        vecs[0]  = '{2'b10, 6'h18, 4'd3};
        vecs[1]  = '{2'b10, 6'h1A, 4'd4};
        vecs[2]  = '{2'b10, 6'h20, 4'd2};
        vecs[3]  = '{2'b10, 6'h22, 4'd6};
        vecs[4]  = '{2'b10, 6'h24, 4'd0};
        vecs[5]  = '{2'b10, 6'h25, 4'd1};
        vecs[6]  = '{2'b10, 6'h2A, 4'd7};
        vecs[7]  = '{2'b10, 6'h00, 4'd8};
        vecs[8]  = '{2'b00, 6'h20, 4'd8};
        vecs[9]  = '{2'b01, 6'h18, 4'd8};
        vecs[10] = '{2'b11, 6'h22, 4'd5};
`ifdef ALU_CTRL_UNSIGNED_EN
        vecs[11] = '{2'b10, 6'h19, 4'd9};
        vecs[12] = '{2'b10, 6'h1B, 4'd10};
`else
        vecs[11] = '{2'b10, 6'h19, 4'd8};
        vecs[12] = '{2'b10, 6'h1B, 4'd8};
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", res_hi, 0);
        check("rst_lo", res_lo, 0);
        check("rst_valid", res_valid, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_stall", stall, 0);
        check("rst_ready", op_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            alu_op = vecs[i].op;
            funct  = vecs[i].f;
            #1;
            check($sformatf("alu_sel_%0d", i), alu_sel, vecs[i].sel);
        end

        // Non-mult/div ops with op_valid must be ignored.
        issue(6'h20, 32'd1, 32'd2);
        check("ignore_add_ready", op_ready, 1);
        check("ignore_add_valid", res_valid, 0);
`ifndef ALU_CTRL_UNSIGNED_EN
        issue(6'h19, 32'hFFFF_FFFF, 32'd2);
        check("multu_off_sel", alu_sel, 8);
        check("multu_off_ready", op_ready, 1);
`else
        run_check("multu", 6'h19, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_const", res_hi, 1);
        check("multu_lo_const", res_lo, 32'hFFFF_FFFE);
        run_check("divu", 6'h1B, 32'hFFFF_FFF0, 32'd3);
        run_check("divu_zero", 6'h1B, 32'h8000_0001, 32'd0);
`endif

        run_check("mult_m3x7", 6'h18, -32'sd3, 32'd7);
        check("mult_m3x7_hi_const", res_hi, 32'hFFFF_FFFF);
        check("mult_m3x7_lo_const", res_lo, 32'hFFFF_FFEB);
        run_check("div_m7d2", 6'h1A, -32'sd7, 32'd2);
        check("div_m7d2_lo_const", res_lo, 32'hFFFF_FFFD);
        check("div_m7d2_hi_const", res_hi, 32'hFFFF_FFFF);
        run_check("div_5d0", 6'h1A, 32'd5, 32'd0);
        check("div_5d0_lo_const", res_lo, 32'hFFFF_FFFF);
        check("div_5d0_hi_const", res_hi, 32'd5);
        run_check("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_min_m1_lo_const", res_lo, 32'h8000_0000);
        check("div_min_m1_hi_const", res_hi, 32'd0);
        run_check("mult_min_min", 6'h18, 32'h8000_0000, 32'h8000_0000);
        run_check("div_7dm2", 6'h1A, 32'd7, -32'sd2);

        for (int i = 0; i < 24; i++) begin
            rf = ($urandom_range(0, 1) == 0) ? 6'h18 : 6'h1A;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = $urandom_range(1, 20);
                2: rb = -$urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_check($sformatf("rnd%0d", i), rf, ra, rb);
        end

        // DONE held with res_ready low and a new op pending.
        issue(6'h1A, 32'd100, 32'd7);
        wait_res(lat, st);
        check("hold_pre_lo", res_lo, 14);
        check("hold_pre_hi", res_hi, 2);
        @(negedge clk);
        alu_op = 2'b10;
        funct = 6'h18;
        op_a = 32'd9;
        op_b = 32'd9;
        op_valid = 1'b1;
        hold_ok = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (res_lo !== 14 || res_hi !== 2 || op_ready !== 1'b0 || res_valid !== 1'b1 || stall !== 1'b1)
                hold_ok = 1'b0;
        end
        check("hold_stable", hold_ok, 1);
        release_res();
        check("release_idle_ready", op_ready, 1);
        check("release_idle_valid", res_valid, 0);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        check("accept_after_release", op_ready, 0);
        wait_res(lat, st);
        check("accept_after_release_lat", lat, W);
        check("accept_after_release_lo", res_lo, 81);
        release_res();

        // Reset in the middle of BUSY.
        issue(6'h18, 32'd123, 32'd456);
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_hi", res_hi, 0);
        check("midrst_lo", res_lo, 0);
        check("midrst_valid", res_valid, 0);
        check("midrst_dbz", div_by_zero, 0);
        check("midrst_stall", stall, 0);
        check("midrst_ready", op_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("post_rst_6x7", 6'h18, 32'd6, 32'd7);
        check("post_rst_lo_const", res_lo, 42);
        check("post_rst_hi_const", res_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
